// File: rtl/ram_pkg.sv
// Shared types and defaults for the wait-state RAM model.
// Holds the controller state encoding and the index-width helper.
package ram_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 4096;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/ram_wait_model_array.sv
// Word storage with byte-masked synchronous write and a registered read port.
// Contents are never reset; the read register is qualified by the controller.
module ram_array
   import ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   localparam int IDX_W = idx_width(DEPTH),
   localparam int NB    = DATA_W / 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [NB-1:0]     sel_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < NB; i++) begin
            if (sel_i[i]) begin
               mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_wait_model.sv
// Clocked fake SRAM with programmable wait states and a ready/busy/error handshake.
// Optional RAM_RANGE_CHECK_EN rejects addresses >= DEPTH instead of wrapping them.
module ram_wait_model
   import ram_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_ce,
   input  logic                  mem_re,
   input  logic                  mem_we,
   input  logic [DATA_W/8-1:0]   mem_sel,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [DATA_W-1:0]     mem_data_i,
   output logic [DATA_W-1:0]     mem_data_o,
   output logic                  mem_ready,
   output logic                  mem_busy,
   output logic                  mem_err
);

   localparam int IDX_W = idx_width(DEPTH);
   localparam int NB    = DATA_W / 8;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [NB-1:0]       sel_q, sel_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                err_q, err_d;

   logic                is_idle;
   logic                accept;
   logic                access;
   logic                oob;
   logic [ADDR_W-1:0]   eff_addr;
   logic [DATA_W-1:0]   eff_data;
   logic [NB-1:0]       eff_sel;
   logic                eff_rd;
   logic                eff_wr;
   logic [DATA_W-1:0]   rdata;

   assign is_idle = (state_q == ST_IDLE);
   assign accept  = is_idle && mem_ce && (mem_re || mem_we);

   // With zero wait states the access happens on the acceptance edge, so the
   // array must see the live inputs while idle and the latched copy otherwise.
   assign eff_addr = is_idle ? mem_addr_i : addr_q;
   assign eff_data = is_idle ? mem_data_i : data_q;
   assign eff_sel  = is_idle ? mem_sel    : sel_q;
   assign eff_rd   = is_idle ? mem_re     : rd_q;
   assign eff_wr   = is_idle ? (mem_we && !mem_re) : wr_q;

`ifdef RAM_RANGE_CHECK_EN
   assign oob = |(eff_addr >> IDX_W);
`else
   assign oob = 1'b0;
`endif

   assign access = (accept && (WAIT_CYCLES == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == 4'd1));

   ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .we_i    (access && eff_wr && !oob),
      .re_i    (access && eff_rd && !oob),
      .idx_i   (eff_addr[IDX_W-1:0]),
      .sel_i   (eff_sel),
      .wdata_i (eff_data),
      .rdata_o (rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      sel_d   = sel_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d = mem_addr_i;
               data_d = mem_data_i;
               sel_d  = mem_sel;
               rd_d   = mem_re;
               wr_d   = mem_we && !mem_re;
               err_d  = oob;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = WAIT_LD;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   assign mem_ready  = (state_q == ST_RESP);
   assign mem_busy   = !is_idle;
   assign mem_err    = mem_ready && err_q;
   assign mem_data_o = (mem_ready && rd_q && !err_q) ? rdata : '0;

endmodule

// File: tb/tb_ram_wait_model.sv
// Bench for ram_wait_model: directed vector table, reset-abort sequence and
// randomized traffic against a word-array reference model.
module tb_ram_wait_model;

   localparam int W     = 2;
   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ce, mem_re, mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
   logic        mem_ready, mem_busy, mem_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [DEPTH];

   always #5 clk = ~clk;

   ram_wait_model #(
      .DATA_W      (32),
      .DEPTH       (DEPTH),
      .ADDR_W      (32),
      .WAIT_CYCLES (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_ce     (mem_ce),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_sel    (mem_sel),
      .mem_addr_i (mem_addr_i),
      .mem_data_i (mem_data_i),
      .mem_data_o (mem_data_o),
      .mem_ready  (mem_ready),
      .mem_busy   (mem_busy),
      .mem_err    (mem_err)
   );

   typedef struct {
      logic        re;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: a plain word array; reads win over writes, out-of-range
   // addresses either wrap or are rejected depending on the build.
   function automatic void model_op(input logic re, input logic we, input logic [3:0] sel,
                                    input logic [31:0] addr, input logic [31:0] data,
                                    output logic [31:0] rd, output logic err);
      int   idx;
      logic bad;
      idx = int'(addr % 32'd4096);
`ifdef RAM_RANGE_CHECK_EN
      bad = (addr >= 32'd4096);
`else
      bad = 1'b0;
`endif
      err = bad;
      rd  = 32'h0;
      if (re) begin
         if (!bad) rd = mdl[idx];
      end else if (we && !bad) begin
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
         end
      end
   endfunction

   task automatic run_op(input logic re, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_d, input logic exp_e, input string name);
      int          lat    = 0;
      int          busy_n = 0;
      int          rdy_n  = 0;
      logic [31:0] got_d  = 32'h0;
      logic        got_e  = 1'b0;
      logic        stray  = 1'b0;
      @(negedge clk);
      mem_ce = 1'b1; mem_re = re; mem_we = we; mem_sel = sel;
      mem_addr_i = addr; mem_data_i = data;
      @(posedge clk);
      #1;
      // scramble every input while the request is in flight
      mem_ce = 1'b0; mem_re = 1'($urandom_range(0, 1)); mem_we = 1'($urandom_range(0, 1));
      mem_addr_i = 32'd3; mem_data_i = $urandom; mem_sel = 4'($urandom);
      for (int k = 1; k <= W + 3; k++) begin
         @(negedge clk);
         if (mem_busy) busy_n++;
         if (mem_ready) begin
            rdy_n++;
            if (lat == 0) lat = k;
            got_d = mem_data_o;
            got_e = mem_err;
         end else if (mem_data_o !== 32'h0 || mem_err !== 1'b0) begin
            stray = 1'b1;
         end
         if (k == 1) mem_ce = 1'b1;
         if (k == W) mem_ce = 1'b0;
      end
      mem_re = 1'b0; mem_we = 1'b0;
      check({name, " latency"}, 32'(lat), 32'(W + 1));
      check({name, " ready_pulses"}, 32'(rdy_n), 32'd1);
      check({name, " busy_cycles"}, 32'(busy_n), 32'(W + 1));
      check({name, " data"}, got_d, exp_d);
      check({name, " err"}, {31'h0, got_e}, {31'h0, exp_e});
      check({name, " idle_outputs"}, {31'h0, stray}, 32'h0);
   endtask

   initial begin
      logic [31:0] md;
      logic        me;
      logic        r, w;
      logic [3:0]  s;
      logic [31:0] a, d;

      rst = 1'b1; mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
      mem_sel = 4'h0; mem_addr_i = 32'h0; mem_data_i = 32'h0;
      #1;
      check("reset ready", {31'h0, mem_ready}, 32'h0);
      check("reset busy", {31'h0, mem_busy}, 32'h0);
      check("reset err", {31'h0, mem_err}, 32'h0);
      check("reset data", mem_data_o, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      tbl.push_back('{1'b0, 1'b1, 4'hF, 32'd5,    32'hDEADBEEF, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 32'd5,    32'h0,        32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'hF, 32'd7,    32'h11223344, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'h5, 32'd7,    32'hAABBCCDD, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'h0, 32'd7,    32'h0,        32'h11BB33DD, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'hF, 32'd9,    32'h00000055, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 1'b1, 4'hF, 32'd9,    32'hFFFFFFFF, 32'h00000055, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 32'd9,    32'h0,        32'h00000055, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'h0, 32'd9,    32'h12345678, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 32'd9,    32'h0,        32'h00000055, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'hF, 32'd4,    32'h44444444, 32'h0,        1'b0});
`ifdef RAM_RANGE_CHECK_EN
      tbl.push_back('{1'b1, 1'b0, 4'hF, 32'd4100, 32'h0,        32'h0,        1'b1});
      tbl.push_back('{1'b0, 1'b1, 4'hF, 32'd4100, 32'hCAFEF00D, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 32'd4,    32'h0,        32'h44444444, 1'b0});
`else
      tbl.push_back('{1'b1, 1'b0, 4'hF, 32'd4100, 32'h0,        32'h44444444, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'hF, 32'd4100, 32'hCAFEF00D, 32'h0,        1'b0});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 32'd4,    32'h0,        32'hCAFEF00D, 1'b0});
`endif
      foreach (tbl[i]) begin
         model_op(tbl[i].re, tbl[i].we, tbl[i].sel, tbl[i].addr, tbl[i].data, md, me);
         run_op(tbl[i].re, tbl[i].we, tbl[i].sel, tbl[i].addr, tbl[i].data,
                tbl[i].exp_d, tbl[i].exp_e, $sformatf("vec%0d", i));
      end

      // reset lands between acceptance and the access edge of a write
      model_op(1'b0, 1'b1, 4'hF, 32'd2, 32'h0A0B0C0D, md, me);
      run_op(1'b0, 1'b1, 4'hF, 32'd2, 32'h0A0B0C0D, 32'h0, 1'b0, "pre_rst_wr");
      @(negedge clk);
      mem_ce = 1'b1; mem_we = 1'b1; mem_re = 1'b0; mem_sel = 4'hF;
      mem_addr_i = 32'd2; mem_data_i = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      mem_ce = 1'b0; mem_we = 1'b0;
      @(posedge clk);
      #1;
      check("abort busy_before", {31'h0, mem_busy}, 32'h1);
      rst = 1'b1;
      #1;
      check("abort ready", {31'h0, mem_ready}, 32'h0);
      check("abort busy", {31'h0, mem_busy}, 32'h0);
      check("abort err", {31'h0, mem_err}, 32'h0);
      check("abort data", mem_data_o, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_op(1'b1, 1'b0, 4'hF, 32'd2, 32'h0, 32'h0A0B0C0D, 1'b0, "post_rst_rd");

      for (int i = 0; i < 32; i++) begin
         d = $urandom;
         model_op(1'b0, 1'b1, 4'hF, 32'(i), d, md, me);
         run_op(1'b0, 1'b1, 4'hF, 32'(i), d, md, me, $sformatf("preload%0d", i));
      end

      for (int i = 0; i < 60; i++) begin
         r = 1'($urandom_range(0, 1));
         w = r ? 1'($urandom_range(0, 1)) : 1'b1;
         s = 4'($urandom);
         a = 32'($urandom_range(0, 31)) + (($urandom_range(0, 3) == 0) ? 32'd4096 : 32'd0);
         d = $urandom;
         model_op(r, w, s, a, d, md, me);
         run_op(r, w, s, a, d, md, me, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
